// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit/receive slice.
// The optional parity stage is selected with the UART_TX_PARITY_EN macro.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 279;
    localparam int BYTE_W               = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Shared between the transmit and receive sides.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-entry holding register behind a valid/ready port.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dout,
    output logic              busy,
    output logic [2:0]        state
);

    // Handshake: a byte moves from tx_data into the holding register on every
    // rising edge where tx_valid && tx_ready; tx_ready is low while the register is full.
    tx_state_t         st_q, st_n;
    logic [BYTE_W-1:0] shift_q, shift_n;
    logic [BYTE_W-1:0] hold_data, hold_data_n;
    logic              hold_full, hold_full_n;
    logic [2:0]        index_q, index_n;
    logic              dout_q, dout_n;
    logic              ready_q;
    logic              tick, clear, load, accept;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_n;
`endif

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .tick  (tick)
    );

    assign accept = tx_valid && ready_q;

    always_comb begin
        st_n        = st_q;
        shift_n     = shift_q;
        index_n     = index_q;
        dout_n      = dout_q;
        hold_full_n = hold_full;
        hold_data_n = hold_data;
        clear       = 1'b0;
        load        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n       = par_q;
`endif
        if (accept) begin
            hold_full_n = 1'b1;
            hold_data_n = tx_data;
        end

        case (st_q)
            IDLE: begin
                clear  = 1'b1;
                dout_n = 1'b1;
                load   = hold_full;
            end
            START: begin
                if (tick) begin
                    st_n   = DATA;
                    dout_n = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = shift_q >> 1;
                    index_n = index_q + 3'd1;
                    if (index_q == 3'(BYTE_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        st_n   = PARITY;
                        dout_n = par_q;
`else
                        st_n   = STOP;
                        dout_n = 1'b1;
`endif
                    end else begin
                        dout_n = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    st_n   = STOP;
                    dout_n = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    // A byte waiting here starts immediately, with no idle cycle.
                    if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        st_n   = IDLE;
                        dout_n = 1'b1;
                    end
                end
            end
            default: begin
                st_n   = IDLE;
                dout_n = 1'b1;
            end
        endcase

        if (load) begin
            st_n        = START;
            shift_n     = hold_data;
            index_n     = 3'd0;
            dout_n      = 1'b0;
            hold_full_n = 1'b0;
            clear       = 1'b1;
`ifdef UART_TX_PARITY_EN
            par_n       = ^hold_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= IDLE;
            shift_q   <= '0;
            index_q   <= 3'd0;
            dout_q    <= 1'b1;
            hold_full <= 1'b0;
            hold_data <= '0;
            ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            st_q      <= st_n;
            shift_q   <= shift_n;
            index_q   <= index_n;
            dout_q    <= dout_n;
            hold_full <= hold_full_n;
            hold_data <= hold_data_n;
            ready_q   <= ~hold_full_n;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_n;
`endif
        end
    end

    assign tx_ready = ready_q;
    assign dout     = dout_q;
    assign busy     = (st_q != IDLE);
    assign state    = st_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboarded bench for uart_transmitter: accepted bytes are queued as expected
// frames and a line monitor decodes every frame cycle by cycle against them.
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int CPB = 23;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME  = FB * CPB;
  localparam int N_RAND = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       dout;
  logic       busy;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frames = 0;
  int sent = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .dout     (dout),
    .busy     (busy),
    .state    (state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // driver
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 4 * FRAME) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (tx_ready !== 1'b1) begin
      fail_now("send_timeout");
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(b);
    sent++;
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy === 1'b0 && tx_ready === 1'b1) && n < 3 * FRAME);
    if (!(busy === 1'b0 && tx_ready === 1'b1)) fail_now("idle_timeout");
  endtask

  task automatic wait_start(input int s0, output int c);
    int n;
    n = 0;
    while (start_q.size() <= s0 && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (start_q.size() <= s0) begin
      fail_now("start_timeout");
      c = cyc;
    end else begin
      c = start_q[s0];
    end
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic count_busy(input int ncyc, output int nb);
    nb = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) nb++;
    end
  endtask

  // monitor: decode a whole frame against the oldest expected byte
  task automatic check_frame();
    logic [7:0]    b;
    logic [FB-1:0] line;
    logic [2:0]    st [FB];
    logic          bad;
    logic          gd, gb;
    logic [2:0]    gs;
    int            gc;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame: start bit at cycle %0d with nothing queued", cyc);
      return;
    end
    b = exp_q.pop_front();
    frames++;
    start_q.push_back(cyc);
    line = '1;
    line[0] = 1'b0;
    st[0] = 3'd1;
    for (int i = 0; i < 8; i++) begin
      line[1 + i] = b[i];
      st[1 + i] = 3'd2;
    end
`ifdef UART_TX_PARITY_EN
    line[9] = (($countones(b) % 2) == 1);
    st[9] = 3'd3;
`endif
    line[FB - 1] = 1'b1;
    st[FB - 1] = 3'd4;
    for (int k = 0; k < FB; k++) begin
      bad = 1'b0;
      gd = 1'b0; gb = 1'b0; gs = 3'd0; gc = 0;
      for (int c = 0; c < CPB; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (rst) return;
        if (!bad && (dout !== line[k] || busy !== 1'b1 || state !== st[k])) begin
          bad = 1'b1;
          gd = dout; gb = busy; gs = state; gc = c;
        end
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL frame_bit byte=%02h bit=%0d cyc_in_bit=%0d: got dout=%b busy=%b state=%0d, want dout=%b busy=1 state=%0d",
                 b, k, gc, gd, gb, gs, line[k], st[k]);
      end
    end
  endtask

  initial begin : monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else begin
        if (prev === 1'b1 && dout === 1'b0) check_frame();
        prev = rst ? 1'b1 : dout;
      end
    end
  end

  initial begin : watchdog
    #(90000 * 10);
    checks++;
    failures++;
    $display("FAIL watchdog: run exceeded 90000 cycles");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n, c0, s0, g;

    // reset with tx_valid held high: nothing may be accepted
    rst = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'hA7;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("reset_dout", dout, 1);
    chk("reset_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_state", state, 0);
    count_busy(2 * CPB, n);
    chk("reset_no_frame", n, 0);

    // single byte: handshake timing and frame length
    send(8'h55);
    @(negedge clk);
    chk("accept_ready_low", tx_ready, 0);
    chk("accept_busy_low", busy, 0);
    chk("accept_dout_idle", dout, 1);
    @(negedge clk);
    chk("load_ready_high", tx_ready, 1);
    chk("load_busy_high", busy, 1);
    chk("load_dout_start", dout, 0);
    chk("load_state_start", state, 1);
    n = 1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
    end
    chk("busy_len_55", n, FRAME);
    chk("end_state_idle", state, 0);
    chk("end_dout_idle", dout, 1);

    // back-to-back: second byte offered mid-frame
    s0 = start_q.size();
    send(8'hA5);
    repeat (3 * CPB) @(posedge clk);
    #1;
    n = cyc;
    send(8'h3C);
    chk("b2b_accept_immediate", cyc - n, 1);
    n = 0;
    while (tx_ready !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (start_q.size() > s0) chk("b2b_load_cycle", cyc, start_q[s0] + FRAME);
    else fail_now("b2b_first_start");
    chk("b2b_load_dout", dout, 0);
    chk("b2b_load_state", state, 1);
    wait_idle();
    if (start_q.size() > s0 + 1) chk("b2b_gap", start_q[s0 + 1] - start_q[s0], FRAME);
    else fail_now("b2b_second_start");

    // byte accepted on the stop-bit tick edge: exactly one idle cycle
    s0 = start_q.size();
    send(8'h6E);
    wait_start(s0, c0);
    wait_cycle(c0 + FRAME - 1);
    send(8'h91);
    wait_idle();
    if (start_q.size() > s0 + 1) chk("post_stop_gap", start_q[s0 + 1] - start_q[s0], FRAME + 1);
    else fail_now("post_stop_second_start");

    // reset mid-frame with a byte queued
    s0 = start_q.size();
    send(8'hFF);
    wait_start(s0, c0);
    wait_cycle(c0 + FRAME / 2);
    send(8'h12);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sent = sent - exp_q.size();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_dout", dout, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_state", state, 0);
    count_busy(2 * FRAME, n);
    chk("midrst_queued_dropped", n, 0);
    send(8'h81);
    wait_idle();

`ifdef UART_TX_PARITY_EN
    // parity bit values and longer frame
    s0 = start_q.size();
    send(8'h07);
    wait_start(s0, c0);
    wait_cycle(c0 + 9 * CPB + CPB / 2);
    chk("parity_07", dout, 1);
    n = 0;
    while (busy === 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("parity_frame_end", cyc, c0 + FRAME);
    s0 = start_q.size();
    send(8'h03);
    wait_start(s0, c0);
    wait_cycle(c0 + 9 * CPB + CPB / 2);
    chk("parity_03", dout, 0);
    wait_idle();
`endif

    // randomized traffic with random gaps, including back-to-back queuing
    for (int i = 0; i < N_RAND; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        g = $urandom_range(0, FRAME + 10);
        repeat (g) begin
          @(posedge clk);
          #1;
          tx_data = 8'($urandom);
        end
      end
      send(8'($urandom));
    end
    wait_idle();
    repeat (4) @(negedge clk);

    // final report
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("frame_count", frames, sent);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmitter, 8N1 frames: one start bit (low), eight data bits LSB first, one stop bit (high), each exactly CLKS_PER_BIT clock cycles. It is the transmit-side counterpart of the block's UART receiver and shares its bit period (279 cycles) so the two interoperate on one clock domain. Bytes arrive through a valid/ready handshake into a one-entry holding register, so the next byte can be queued while the current frame is on the line.

## Interface
- CLKS_PER_BIT, 279, cycles per serial bit; legal range 2..511
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tx_data  input  8  byte to send; sampled when tx_valid && tx_ready
- tx_valid  input  1  producer has a byte
- tx_ready  output  1  holding register empty; byte accepted on any edge with tx_valid && tx_ready
- dout  output  1  serial line, idle high, registered
- busy  output  1  high while state != IDLE
- state  output  3  FSM state, debug only

## Operation
- Encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4. The 3-bit width is fixed in both configurations.
- Holding register (hold_data, hold_full):
  - Set on accept.
  - Cleared when the FSM loads it.
  - tx_ready = ~hold_full, driven from a register.
  - Accept and load never coincide, because ready is low while full.
- Bit counter counts 0..CLKS_PER_BIT-1. Tick = counter at CLKS_PER_BIT-1; the counter then wraps to 0. Width is $clog2(CLKS_PER_BIT).
- IDLE:
  - dout=1, counter held at 0.
  - If hold_full: load shift register from hold_data, clear hold_full, index=0, go to START, dout<=0.
- START: dout=0. On tick, go to DATA with dout<=shift[0].
- DATA:
  - dout = current bit.
  - On tick: shift right, index+1, dout<=next bit.
  - After the tick with index==7: go to PARITY if enabled, else STOP.
- PARITY: dout = even parity of the byte (XOR of 8 bits). On tick, go to STOP.
- STOP: dout=1. On tick:
  - If hold_full: load it and go directly to START (dout<=0, zero idle gap).
  - Otherwise go to IDLE.
- tx_data is ignored unless the handshake fires. The shift register is independent of later tx_data changes.

## Timing
- Reset values: dout=1, tx_ready=1, busy=0, state=IDLE, counter=0, index=0, hold_full=0, shift=0.
- Accept on edge N (FSM idle): hold_full high after N. Load on edge N+1: dout low and busy high after N+1. tx_ready falls after N and rises after N+1.
- Every line bit, including start and stop, lasts exactly CLKS_PER_BIT cycles.
- Frame length:
  - 10·CLKS_PER_BIT cycles (2790) without parity.
  - 11·CLKS_PER_BIT cycles (3069) with parity.
- Back-to-back: a byte queued before the STOP tick starts its START bit on the cycle immediately after the stop bit ends. There is no gap.
- Byte queued after the STOP tick: IDLE lasts exactly one cycle, then START.
- Reset mid-frame: on the reset edge dout=1, the FSM returns to IDLE, and the queued byte is discarded. There is no partial-frame completion.
- tx_valid during reset is ignored.

## Configuration
- UART_TX_PARITY_EN
  - Defined: the PARITY state is inserted between DATA and STOP and carries even parity.
  - Undefined: DATA goes straight to STOP, the PARITY encoding is unused, and the frame is 8N1.

## Structure
- Package uart_pkg holds:
  - State localparams (IDLE..STOP).
  - Default CLKS_PER_BIT=279.
  - Byte width constant 8.
- Sub-module uart_baud_counter (parameter CLKS_PER_BIT):
  - Inputs: clk, rst, clear (hold at 0 in IDLE and on load).
  - Output: tick.
  - Intended for reuse by the receive side.

## Test plan
- Reset: assert rst for 3 cycles with tx_valid=1 → dout=1, tx_ready=1, busy=0, state=0, and no frame starts.
- Single byte 0x55, no parity → dout 0,1,0,1,0,1,0,1,0,1, each bit 279 cycles. busy is high for 2790 cycles, then IDLE.
- Back-to-back 0xA5 then 0x3C, second offered mid-frame → second accepted immediately. Its start bit begins the cycle after the first stop bit ends. tx_ready stays low until it is loaded.
- Reset at cycle 1000 of a 0xFF frame → dout=1 on the next cycle, the queued byte is dropped, and the next accepted byte 0x81 frames correctly.
- UART_TX_PARITY_EN, byte 0x07 → parity bit 1 and frame length 3069 cycles. Byte 0x03 → parity bit 0.
- Loopback into the team's UART receiver, 256 random bytes, no parity → every byte reconstructed with valid asserted once per frame.
